// File: rtl/red_pitaya_trig_arb_pkg.sv
// Shared types and register map for the trigger arbiter.
package red_pitaya_trig_arb_pkg;

  localparam int IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  localparam logic [15:0] REG_ENABLE   = 16'h0000;
  localparam logic [15:0] REG_TIMEOUT  = 16'h0004;
  localparam logic [15:0] REG_STATUS   = 16'h0008;
  localparam logic [15:0] REG_FLAGS    = 16'h000C;
  localparam logic [15:0] REG_TRIG_CNT = 16'h0010;
  localparam logic [15:0] REG_FORCE    = 16'h0014;

endpackage

// File: rtl/red_pitaya_trigger_arbiter_rr_pick.sv
// Round-robin picker: first eligible requester after last_i, wrapping, last_i itself checked last.
module red_pitaya_rr_pick
  import red_pitaya_trig_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  eligible_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             found_o,
  output logic [IDX_W-1:0] next_o
);

  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  always_comb begin
    int cand;
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    found_o = 1'b0;
    next_o  = '0;
    cand    = 0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = int'(last_i) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found_o && eligible_i[cand[SW-1:0]]) begin
        found_o = 1'b1;
        next_o  = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/red_pitaya_trigger_arbiter.sv
// Round-robin owner of a shared trigger block: grants, rearms, routes the trigger, releases.
module red_pitaya_trigger_arbiter
  import red_pitaya_trig_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int TOBITS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] done_i,
  output logic [NREQ-1:0] grant_o,
  output logic [NREQ-1:0] trig_o,
  output logic            rearm_o,
  input  logic            trig_i,
  input  logic [15:0]     addr,
  input  logic            wen,
  input  logic            ren,
  output logic            ack,
  output logic [31:0]     rdata,
  input  logic [31:0]     wdata
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [NREQ-1:0]     trig_q, trig_d;
  logic                rearm_q, rearm_d;
  logic                ack_q, ack_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [NREQ-1:0]     enable_q, enable_d;
  logic [TOBITS-1:0]   timeout_q, timeout_d;
  logic [NREQ-1:0]     flags_q, flags_d;
  logic [TOBITS-1:0]   cnt_q, cnt_d;
  logic [31:0]         trig_cnt_q, trig_cnt_d;

  logic                found;
  logic [IDX_W-1:0]    pick_idx;
  logic                owner_req, owner_done, force_rel;

  red_pitaya_rr_pick #(.NREQ(NREQ)) u_pick (
    .eligible_i (req_i & enable_q),
    .last_i     (last_q),
    .found_o    (found),
    .next_o     (pick_idx)
  );

  // grant_q is one-hot on the owner, so it doubles as the owner select mask.
  assign owner_req  = |(req_i & grant_q);
  assign owner_done = |(done_i & grant_q);
  assign force_rel  = wen && (addr == REG_FORCE);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    grant_d    = grant_q;
    trig_d     = '0;
    rearm_d    = 1'b0;
    cnt_d      = cnt_q;
    trig_cnt_d = trig_cnt_q;
    flags_d    = flags_q;
    if (wen && addr == REG_FLAGS) flags_d = flags_q & ~wdata[NREQ-1:0];

    unique case (state_q)
      ST_IDLE: begin
        if (force_rel) begin
          state_d = ST_RELEASE;
        end else if (found) begin
          owner_d = pick_idx;
          grant_d = NREQ'(1) << pick_idx;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        cnt_d = '0;
        if (force_rel || !owner_req) begin
          state_d = ST_RELEASE;
        end else begin
          rearm_d = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Priority: force, withdrawal, trigger, then timeout.
        if (force_rel || !owner_req) begin
          state_d = ST_RELEASE;
        end else if (trig_i) begin
          trig_d     = grant_q;
          trig_cnt_d = trig_cnt_q + 32'd1;
          state_d    = ST_HOLD;
        end else if (timeout_q != '0 && cnt_q == timeout_q - TOBITS'(1)) begin
          flags_d = flags_d | grant_q;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + TOBITS'(1);
        end
      end
      ST_HOLD: begin
        if (force_rel || owner_done || !owner_req) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        grant_d = '0;
        if (|grant_q) last_d = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    enable_d  = enable_q;
    timeout_d = timeout_q;
    ack_d     = wen | ren;
    rdata_d   = '0;
    if (wen && addr == REG_ENABLE)  enable_d  = wdata[NREQ-1:0];
    if (wen && addr == REG_TIMEOUT) timeout_d = wdata[TOBITS-1:0];
    if (ren) begin
      case (addr)
        REG_ENABLE:   rdata_d = 32'(enable_q);
        REG_TIMEOUT:  rdata_d = 32'(timeout_q);
        REG_STATUS:   rdata_d = {22'd0, state_q[1:0], 1'b0, owner_q, 3'd0, |grant_q};
        REG_FLAGS:    rdata_d = 32'(flags_q);
        REG_TRIG_CNT: rdata_d = trig_cnt_q;
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    if (rst_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      last_q     <= IDX_W'(NREQ - 1);
      grant_q    <= '0;
      trig_q     <= '0;
      rearm_q    <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      enable_q   <= '0;
      timeout_q  <= '0;
      flags_q    <= '0;
      cnt_q      <= '0;
      trig_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      trig_q     <= trig_d;
      rearm_q    <= rearm_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      enable_q   <= enable_d;
      timeout_q  <= timeout_d;
      flags_q    <= flags_d;
      cnt_q      <= cnt_d;
      trig_cnt_q <= trig_cnt_d;
    end
  end

  assign grant_o = grant_q;
  assign trig_o  = trig_q;
  assign rearm_o = rearm_q;
  assign ack     = ack_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_red_pitaya_trigger_arbiter.sv
// Scoreboard bench: stimulus pushes expected grant/trig/rearm events and bus read data; a monitor pops and compares.
module tb_red_pitaya_trigger_arbiter;

  localparam int NREQ   = 4;
  localparam int TOBITS = 32;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [NREQ-1:0] req_i, done_i;
  logic [NREQ-1:0] grant_o, trig_o;
  logic            rearm_o, trig_i;
  logic [15:0]     addr;
  logic            wen, ren, ack;
  logic [31:0]     rdata, wdata;

  red_pitaya_trigger_arbiter #(.NREQ(NREQ), .TOBITS(TOBITS)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .done_i  (done_i),
    .grant_o (grant_o),
    .trig_o  (trig_o),
    .rearm_o (rearm_o),
    .trig_i  (trig_i),
    .addr    (addr),
    .wen     (wen),
    .ren     (ren),
    .ack     (ack),
    .rdata   (rdata),
    .wdata   (wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NREQ-1:0] val;
    int              at;
  } ev_t;

  typedef struct {
    logic [31:0] val;
    string       name;
  } rd_t;

  ev_t grant_exp[$];
  ev_t trig_exp[$];
  int  rearm_exp[$];
  rd_t bus_exp[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected value 0x%0h at cycle %0d, expected no event", name, act, cyc);
  endtask

  task automatic exp_grant(input logic [NREQ-1:0] v, input int at);
    ev_t e;
    e.val = v;
    e.at  = at;
    grant_exp.push_back(e);
  endtask

  task automatic exp_trig(input logic [NREQ-1:0] v, input int at);
    ev_t e;
    e.val = v;
    e.at  = at;
    trig_exp.push_back(e);
  endtask

  // Monitor: samples on the falling edge, half a cycle away from the DUT's active edge.
  logic [NREQ-1:0] grant_prev = '0;
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (grant_o !== grant_prev) begin
        if (grant_exp.size() == 0) unexpected("grant", 64'(grant_o));
        else begin
          ev_t e;
          e = grant_exp.pop_front();
          check("grant_val", 64'(grant_o), 64'(e.val));
          check("grant_cyc", 64'(cyc), 64'(e.at));
        end
        grant_prev = grant_o;
      end
      if (trig_o !== '0) begin
        if (trig_exp.size() == 0) unexpected("trig", 64'(trig_o));
        else begin
          ev_t e;
          e = trig_exp.pop_front();
          check("trig_val", 64'(trig_o), 64'(e.val));
          check("trig_cyc", 64'(cyc), 64'(e.at));
        end
      end
      if (rearm_o !== 1'b0) begin
        if (rearm_exp.size() == 0) unexpected("rearm", 64'(rearm_o));
        else check("rearm_cyc", 64'(cyc), 64'(rearm_exp.pop_front()));
      end
      if (ack !== 1'b0) begin
        if (bus_exp.size() == 0) unexpected("ack", 64'(rdata));
        else begin
          rd_t r;
          r = bus_exp.pop_front();
          check(r.name, 64'(rdata), 64'(r.val));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    rd_t r;
    r.val  = 32'd0;
    r.name = "wr_rdata";
    bus_exp.push_back(r);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    @(negedge clk);
    wen   = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, input logic [31:0] exp, input string name);
    rd_t r;
    r.val  = exp;
    r.name = name;
    bus_exp.push_back(r);
    addr = a;
    ren  = 1'b1;
    @(negedge clk);
    ren  = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, t;
    rst_i  = 1'b1;
    req_i  = '0;
    done_i = '0;
    trig_i = 1'b0;
    addr   = '0;
    wen    = 1'b0;
    ren    = 1'b0;
    wdata  = '0;
    tick(3);
    check("reset_outs", {grant_o, trig_o, rearm_o, ack, rdata}, '0);
    rst_i = 1'b0;

    // Reset values of the register file, then enable everyone.
    bus_rd(16'h00, 32'h0, "enable_rst");
    bus_rd(16'h04, 32'h0, "timeout_rst");
    bus_rd(16'h08, 32'h0, "status_rst");
    bus_rd(16'h0C, 32'h0, "flags_rst");
    bus_rd(16'h10, 32'h0, "count_rst");
    bus_wr(16'h00, 32'hF);
    bus_rd(16'h00, 32'hF, "enable_rd");
    bus_rd(16'h18, 32'h0, "bad_addr");

    // Requesters 0 and 2: 0 wins first; grant +1, rearm +2.
    c = cyc;
    req_i = 4'b0101;
    exp_grant(4'b0001, c + 1);
    rearm_exp.push_back(c + 2);
    wait_cyc(c + 3);
    t = cyc;
    exp_trig(4'b0001, t + 1);
    trig_i = 1'b1;
    tick(1);
    trig_i = 1'b0;
    done_i = 4'b0100;          // non-owner done, ignored
    tick(1);
    c = cyc;
    done_i = 4'b0001;
    exp_grant(4'b0000, c + 2);
    exp_grant(4'b0100, c + 3);
    rearm_exp.push_back(c + 4);
    tick(1);
    done_i = '0;
    wait_cyc(c + 5);

    // Owner 2: routed trigger, second trigger in HOLD dropped.
    bus_rd(16'h10, 32'd1, "count_1");
    t = cyc;
    exp_trig(4'b0100, t + 1);
    trig_i = 1'b1;
    tick(1);
    tick(1);                   // trig_i still high on the first HOLD cycle
    trig_i = 1'b0;
    bus_rd(16'h08, 32'h321, "status_hold");
    bus_rd(16'h10, 32'd2, "count_2");
    bus_wr(16'h04, 32'd100);

    // Force release in HOLD, then owner 0 times out after 100 WAIT cycles.
    c = cyc;
    exp_grant(4'b0000, c + 2);
    exp_grant(4'b0001, c + 3);
    rearm_exp.push_back(c + 4);
    exp_grant(4'b0000, c + 105);
    exp_grant(4'b0100, c + 106);
    rearm_exp.push_back(c + 107);
    bus_wr(16'h14, 32'h0);
    wait_cyc(c + 108);

    // Owner 2 withdraws in WAIT: aborted, no flag; requester 0 regranted.
    c = cyc;
    req_i = 4'b0001;
    exp_grant(4'b0000, c + 2);
    exp_grant(4'b0001, c + 3);
    rearm_exp.push_back(c + 4);
    tick(1);
    bus_rd(16'h0C, 32'h1, "flags_timeout");
    bus_wr(16'h0C, 32'h1);
    bus_rd(16'h0C, 32'h0, "flags_w1c");

    // Force in WAIT, single requester regranted, T = 10 with trigger on the expiry cycle.
    c = cyc;
    exp_grant(4'b0000, c + 2);
    exp_grant(4'b0001, c + 3);
    rearm_exp.push_back(c + 4);
    bus_wr(16'h14, 32'hDEAD);
    bus_wr(16'h04, 32'd10);
    wait_cyc(c + 13);
    exp_trig(4'b0001, c + 14);
    trig_i = 1'b1;
    tick(1);
    trig_i = 1'b0;
    bus_rd(16'h0C, 32'h0, "flags_trig_wins");
    bus_rd(16'h10, 32'd3, "count_3");

    // Clearing the owner's enable does not abort; it only blocks the next pick.
    bus_wr(16'h00, 32'hE);
    c = cyc;
    done_i = 4'b0001;
    exp_grant(4'b0000, c + 2);
    tick(1);
    done_i = '0;
    tick(6);
    bus_rd(16'h08, 32'h0, "status_idle");

    // Re-enable, reach HOLD, then reset mid-operation.
    c = cyc;
    exp_grant(4'b0001, c + 2);
    rearm_exp.push_back(c + 3);
    bus_wr(16'h00, 32'hF);
    wait_cyc(c + 4);
    exp_trig(4'b0001, c + 5);
    trig_i = 1'b1;
    tick(1);
    trig_i = 1'b0;
    tick(1);
    c = cyc;
    rst_i = 1'b1;
    exp_grant(4'b0000, c + 1);
    tick(1);
    rst_i = 1'b0;
    check("reset_mid_outs", {grant_o, trig_o, rearm_o, ack, rdata}, '0);
    bus_rd(16'h00, 32'h0, "enable_after_rst");
    bus_rd(16'h04, 32'h0, "timeout_after_rst");
    bus_rd(16'h08, 32'h0, "status_after_rst");
    bus_rd(16'h10, 32'h0, "count_after_rst");
    tick(5);

    check("grant_pending", 64'(grant_exp.size()), 64'd0);
    check("trig_pending", 64'(trig_exp.size()), 64'd0);
    check("rearm_pending", 64'(rearm_exp.size()), 64'd0);
    check("bus_pending", 64'(bus_exp.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
